// File: rtl/addsub_pipe.sv
// Pipelined add/subtract unit: carry chain split into NSEG segments, one register stage each,
// with ALU flags and a valid/ready handshake. One op per cycle, latency NSEG.
module addsub_pipe #(
    parameter int WIDTH = 32,
    parameter int NSEG  = 2,
    parameter int TAG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_rs2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_rd,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_carry,
    output logic             o_ovf
);
    localparam int SW = WIDTH / NSEG;

    logic             adv;
    logic             accept;
    logic [WIDTH-1:0] b_in;
    logic [NSEG-1:0]  v_q;
    logic [TAG_W-1:0] tag_q [NSEG];

    // The whole pipe advances as one; a stalled output freezes every stage.
    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv & ~i_flush;
    assign accept  = i_valid & o_ready;
    assign b_in    = i_rs2 ^ {WIDTH{i_sub}};
    assign o_valid = v_q[NSEG-1];
    assign o_tag   = tag_q[NSEG-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v_q <= '0;
        end else if (i_flush) begin
            v_q <= '0;
        end else if (adv) begin
            v_q <= (v_q << 1) | NSEG'(accept);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NSEG; k++) tag_q[k] <= '0;
        end else if (adv) begin
            tag_q[0] <= i_tag;
            for (int k = 1; k < NSEG; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int LO = k * SW;
        localparam int HI = (k + 1) * SW;

        logic [SW-1:0] seg_a;
        logic [SW-1:0] seg_b;
        logic          cin;
        logic [SW:0]   sum;
        logic [HI-1:0] res_d;
        logic [HI-1:0] res_q;
        logic          cout_q;

        if (k == 0) begin : g_in
            assign seg_a = i_rs1[SW-1:0];
            assign seg_b = b_in[SW-1:0];
            assign cin   = i_sub;
            assign res_d = sum[SW-1:0];
        end else begin : g_in
            assign seg_a = g_stg[k-1].g_up.a_q[HI-1:LO];
            assign seg_b = g_stg[k-1].g_up.b_q[HI-1:LO];
            assign cin   = g_stg[k-1].cout_q;
            assign res_d = {sum[SW-1:0], g_stg[k-1].res_q};
        end

        assign sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SW{1'b0}}, cin};

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                res_q  <= '0;
                cout_q <= 1'b0;
            end else if (adv) begin
                res_q  <= res_d;
                cout_q <= sum[SW];
            end
        end

        // Operand segments not yet added ride along with the op.
        if (k < NSEG - 1) begin : g_up
            logic [WIDTH-1:HI] a_d;
            logic [WIDTH-1:HI] b_d;
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] b_q;

            if (k == 0) begin : g_src
                assign a_d = i_rs1[WIDTH-1:HI];
                assign b_d = b_in[WIDTH-1:HI];
            end else begin : g_src
                assign a_d = g_stg[k-1].g_up.a_q[WIDTH-1:HI];
                assign b_d = g_stg[k-1].g_up.b_q[WIDTH-1:HI];
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == NSEG - 1) begin : g_flag
            logic zero_q;
            logic neg_q;
            logic ovf_q;

            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    zero_q <= 1'b0;
                    neg_q  <= 1'b0;
                    ovf_q  <= 1'b0;
                end else if (adv) begin
                    zero_q <= (res_d == '0);
                    neg_q  <= res_d[WIDTH-1];
                    ovf_q  <= seg_a[SW-1] ^ seg_b[SW-1] ^ sum[SW-1] ^ sum[SW];
                end
            end

            assign o_rd    = res_q;
            assign o_carry = cout_q;
            assign o_zero  = zero_q;
            assign o_neg   = neg_q;
            assign o_ovf   = ovf_q;
        end
    end

endmodule
